// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } arb_state_e;

    localparam int P_CPU = 0;
    localparam int P_LDR = 1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_MEM_RD_LAT = 1;

    // Index of the granted port from a one-hot (or empty) grant vector.
    function automatic logic grant_index(input logic [1:0] grant);
        return grant[P_LDR];
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin picker; the pointer register lives in the caller.
module dmem_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_o
);

    // Single requester always wins; on contention the pointer selects the winner.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rr_ptr_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates CPU and loader access to a single-port data memory, one transaction at a time.
// Optional address range checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MEM_RD_LAT = DEF_MEM_RD_LAT
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    input  logic              p0_rready,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    input  logic              p1_rready,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    localparam int                CNT_W    = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(MEM_RD_LAT - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    arb_state_e        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              idx_q, idx_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        req_valid_s;
    logic [1:0]        grant_s;
    logic              oob_s;
    logic              sel_rready_s;
    logic              mem_active_s;

    assign req_valid_s = {p1_valid, p0_valid};

    dmem_rr_pick u_pick (
        .valid_i  (req_valid_s),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (grant_s)
    );

    // Out-of-range flag for the latched address; constant 0 when checking is compiled out.
    always_comb begin
        if (BOUNDS_EN) begin
            oob_s = ({1'b0, addr_q} >= DEPTH_X);
        end else begin
            oob_s = 1'b0;
        end
        sel_rready_s = idx_q ? p1_rready : p0_rready;
    end

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            idx_q    <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            err_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic for the IDLE -> ACCESS -> (WAIT) -> RESP cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    idx_d    = grant_index(grant_s);
                    rr_ptr_d = ~grant_index(grant_s);
                    state_d  = ST_ACCESS;
                    if (grant_s[P_LDR]) begin
                        write_d = p1_write;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                    end else begin
                        write_d = p0_write;
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_d = {CNT_W{1'b0}};
                if (oob_s) begin
                    err_d   = 1'b1;
                    rdata_d = {DATA_W{1'b0}};
                    state_d = ST_RESP;
                end else if (write_q) begin
                    err_d   = 1'b0;
                    rdata_d = {DATA_W{1'b0}};
                    state_d = ST_RESP;
                end else begin
                    err_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (sel_rready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: memory strobes from the latched request, response muxed to the winner.
    always_comb begin
        mem_active_s = ((state_q == ST_ACCESS) && !oob_s) || (state_q == ST_WAIT);
        mem_write    = (state_q == ST_ACCESS) && write_q && !oob_s;
        mem_read     = mem_active_s && !write_q;
        mem_addr     = mem_active_s ? addr_q : {ADDR_W{1'b0}};
        mem_wdata    = (mem_active_s && write_q) ? wdata_q : {DATA_W{1'b0}};

        p0_ready  = (state_q == ST_IDLE) && grant_s[P_CPU] && !reset;
        p1_ready  = (state_q == ST_IDLE) && grant_s[P_LDR] && !reset;
        p0_rvalid = (state_q == ST_RESP) && (idx_q == 1'b0);
        p1_rvalid = (state_q == ST_RESP) && (idx_q == 1'b1);
        p0_rdata  = p0_rvalid ? rdata_q : {DATA_W{1'b0}};
        p1_rdata  = p1_rvalid ? rdata_q : {DATA_W{1'b0}};
        p0_err    = p0_rvalid && err_q;
        p1_err    = p1_rvalid && err_q;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: directed scenarios then randomized two-port traffic against a transaction model.
module tb_dmem_port_arbiter;

    localparam int LAT   = 1;
    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid = 1'b0, p0_write = 1'b0, p0_rready = 1'b0;
    logic        p1_valid = 1'b0, p1_write = 1'b0, p1_rready = 1'b0;
    logic [31:0] p0_addr = 32'd0, p0_wdata = 32'd0, p1_addr = 32'd0, p1_wdata = 32'd0;
    logic        p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MEM_RD_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rready(p0_rready), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rready(p1_rready), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory with one cycle of read latency.
    bit [31:0] mem_arr [0:511];
    always_ff @(posedge clock) begin
        if (mem_write) mem_arr[mem_addr[8:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem_arr[mem_addr[8:0]];
    end

    // Transaction-level reference state.
    bit [31:0]   ref_mem [0:511];
    bit          pend [2];
    bit          pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    bit          pref;
    bit          bounds;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        p0_valid = pend[0]; p0_write = pw[0]; p0_addr = pa[0]; p0_wdata = pd[0];
        p1_valid = pend[1]; p1_write = pw[1]; p1_addr = pa[1]; p1_wdata = pd[1];
    endtask

    task automatic set_req(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        pend[p] = 1'b1; pw[p] = w; pa[p] = a; pd[p] = d;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 32'($urandom_range(250, 299));
        else return 32'($urandom_range(0, 15));
    endfunction

    // One arbitration round starting in an IDLE cycle, carried through to the response handshake.
    task automatic round(input int rdelay, input bit early);
        int          w, cyc, exp_lat;
        bit          ew, inb;
        logic [31:0] ea, ed, er;
        drive(); #1;
        check("idle_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
        check("idle_mem", {mem_write, mem_read}, 2'b00);
        check("idle_addr", mem_addr, 32'd0);
        w = (pend[0] && pend[1]) ? int'(pref) : (pend[0] ? 0 : 1);
        check("grant", {p1_ready, p0_ready}, (w == 1) ? 2'b10 : 2'b01);
        ew = pw[w]; ea = pa[w]; ed = pd[w];
        pend[w] = 1'b0;
        pref = (w == 0);
        inb = !(bounds && ea >= DEPTH);
        exp_lat = (ew || !inb) ? 2 : 2 + LAT;
        er = (ew || !inb) ? 32'd0 : ref_mem[ea[8:0]];
        if (ew && inb) ref_mem[ea[8:0]] = ed;

        @(negedge clock); drive();
        if (early) begin
            if (w == 1) p1_rready = 1'b1; else p0_rready = 1'b1;
        end
        #1;
        check("acc_wr", mem_write, ew && inb);
        check("acc_rd", mem_read, !ew && inb);
        check("acc_addr", mem_addr, inb ? ea : 32'd0);
        if (ew && inb) check("acc_wdata", mem_wdata, ed);
        cyc = 1;
        while (!((w == 1) ? p1_rvalid : p0_rvalid) && cyc < 40) begin
            check("busy_ready", {p1_ready, p0_ready}, 2'b00);
            if (cyc >= 2) check("wait_rd", mem_read, 1'b1);
            @(negedge clock); #1;
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("rdata", (w == 1) ? p1_rdata : p0_rdata, er);
        check("err", (w == 1) ? p1_err : p0_err, !inb);
        check("other_rvalid", (w == 1) ? p0_rvalid : p1_rvalid, 1'b0);
        check("resp_ready", {p1_ready, p0_ready}, 2'b00);
        if (!early) begin
            for (int k = 0; k < rdelay; k++) begin
                @(negedge clock); #1;
                check("hold_rvalid", (w == 1) ? p1_rvalid : p0_rvalid, 1'b1);
                check("hold_rdata", (w == 1) ? p1_rdata : p0_rdata, er);
                check("hold_ready", {p1_ready, p0_ready}, 2'b00);
            end
            if (w == 1) p1_rready = 1'b1; else p0_rready = 1'b1;
        end
        @(negedge clock);
        p0_rready = 1'b0; p1_rready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0; drive();
        repeat (2) @(negedge clock);
        #1;
        check("rst_out", {p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err,
                          mem_write, mem_read}, 8'd0);
        check("rst_bus", {p0_rdata, p1_rdata}, 64'd0);
        check("rst_mem", {mem_addr, mem_wdata}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        pref = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef DMEM_BOUNDS_CHECK_EN
        bounds = 1'b1;
`else
        bounds = 1'b0;
`endif
        pend[0] = 1'b0; pend[1] = 1'b0; pw[0] = 1'b0; pw[1] = 1'b0;
        pa[0] = 32'd0; pa[1] = 32'd0; pd[0] = 32'd0; pd[1] = 32'd0;
        pulse_reset();

        // Store then load back through the CPU port.
        set_req(0, 1'b1, 32'd2, 32'd256);
        round(0, 1'b0);
        set_req(0, 1'b0, 32'd2, 32'd0);
        round(0, 1'b0);

        // Contention from reset alternates starting with port 0; port 1 response held 5 cycles.
        pulse_reset();
        set_req(0, 1'b1, 32'd5, 32'h0000_00a5);
        set_req(1, 1'b1, 32'd6, 32'h0000_005a);
        round(0, 1'b0);
        set_req(0, 1'b0, 32'd6, 32'd0);
        round(5, 1'b0);
        set_req(1, 1'b0, 32'd5, 32'd0);
        round(0, 1'b0);
        round(1, 1'b0);

        // Reset while the load waits on memory: no response, strobes drop.
        set_req(0, 1'b0, 32'd2, 32'd0);
        drive(); #1;
        check("r5_ready", p0_ready, 1'b1);
        pend[0] = 1'b0;
        @(negedge clock); drive(); #1;
        check("r5_acc_rd", mem_read, 1'b1);
        @(negedge clock); #1;
        check("r5_wait_rd", mem_read, 1'b1);
        reset = 1'b1;
        @(negedge clock); #1;
        check("r5_abort", {mem_read, mem_write, p0_rvalid, p1_rvalid}, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        pref = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("r5_quiet", {mem_read, mem_write, p0_rvalid, p1_rvalid}, 4'b0000);
            @(negedge clock);
        end
        set_req(1, 1'b0, 32'd5, 32'd0);
        set_req(0, 1'b0, 32'd2, 32'd0);
        round(0, 1'b0);
        round(0, 1'b0);

        // Load beyond DEPTH: an error response when range checking is built in.
        set_req(1, 1'b0, 32'd300, 32'd0);
        round(0, 1'b0);

        // Randomized traffic on both ports.
        for (int r = 0; r < 200; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0)
                    set_req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            if (!pend[0] && !pend[1])
                set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            round(int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
